iter_divider: RTL

- Parametrised iterative restoring divider with integrated control FSM and datapath; successor to the fixed-width divider controller.
- Adds a WIDTH parameter, signed/unsigned mode, divide-by-zero detection, busy flag and a level start/done handshake.
- Produces one quotient bit per clock and presents registered quotient/remainder to the surrounding arithmetic unit.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 26 ++
 rtl/iter_divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// The state encoding is 2 bits: idle, iterate, sign fix-up, done.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  // Every quotient bit is set on divide-by-zero, whatever the width.
  localparam logic DbzQuotFill = 1'b1;

  // Wide enough to hold the iteration count WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and either keep the difference (quotient bit 1) or restore it.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // partial < 2*divisor, so the sign of a WIDTH+1-bit difference is exact
  always_comb begin
    partial = {rem_i, dvd_msb_i};
    trial   = partial - {1'b0, dvs_i};
    qbit_o  = ~trial[WIDTH];
    rem_o   = qbit_o ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per clock, optional signed
// mode, divide-by-zero flag and a level start / done handshake.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e state_q;
  logic [CntW-1:0]  cnt_q;
  logic             sign_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             sign_in;
  logic             dvd_neg_in;
  logic             dvs_neg_in;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;
  logic             neg_quot;
  logic             neg_rem;

  // Two's-complement magnitude; the most-negative value maps onto itself,
  // which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    sign_in    = signed_mode & SIGNED_EN;
    dvd_neg_in = sign_in & dividend[WIDTH-1];
    dvs_neg_in = sign_in & divisor[WIDTH-1];
    dvd_mag    = dvd_neg_in ? -dividend : dividend;
    dvs_mag    = dvs_neg_in ? -divisor : divisor;
    neg_quot   = sign_q & (dvd_neg_q ^ dvs_neg_q);
    neg_rem    = sign_q & dvd_neg_q;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dq_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_nxt),
    .qbit_o    (qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      remd_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            sign_q    <= sign_in;
            dvd_neg_q <= dvd_neg_in;
            dvs_neg_q <= dvs_neg_in;
            dq_q      <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            cnt_q     <= CntW'(WIDTH);
            busy_q    <= 1'b1;
            if (divisor == '0) begin
              // Raw dividend, not its magnitude, is reported as remainder
              quot_q  <= {WIDTH{DbzQuotFill}};
              remd_q  <= dividend;
              dbz_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= StIter;
            end
          end
        end
        StIter: begin
          rem_q <= rem_nxt;
          dq_q  <= {dq_q[WIDTH-2:0], qbit};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // Truncating division: remainder follows the dividend's sign
          quot_q  <= neg_quot ? -dq_q : dq_q;
          remd_q  <= neg_rem ? -rem_q : rem_q;
          state_q <= StDone;
        end
        StDone: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (!start) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
